// File: rtl/decoder_2x4_stream_if.sv
// Stream bus for decoder_2x4_stream: code input handshake, one-hot output handshake
// and per-code counter readback.
interface decoder_2x4_stream_if #(
    parameter int unsigned CNT_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       in_code;
    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_onehot;
    logic             clr_cnt;
    logic [1:0]       cnt_sel;
    logic [CNT_W-1:0] cnt_val;

    modport slave (
        input  in_valid, in_code, out_ready, clr_cnt, cnt_sel,
        output in_ready, out_valid, out_onehot, cnt_val
    );

    modport master (
        output in_valid, in_code, out_ready, clr_cnt, cnt_sel,
        input  in_ready, out_valid, out_onehot, cnt_val
    );
endinterface

// File: rtl/decoder_2x4_stream.sv
// 2-entry FIFO of 2-bit codes presenting the head as a one-hot word.
// Optional per-code transfer counters are enabled by DECODER_2X4_STREAM_CNT_EN.
module decoder_2x4_stream #(
    parameter int unsigned CNT_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    decoder_2x4_stream_if.slave   bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t     r_state;
    logic [1:0] r_head;
    logic [1:0] r_tail;
    logic [3:0] r_onehot;

    logic w_push;
    logic w_pop;
    logic w_in_ready;
    logic w_out_valid;
    logic [CNT_W-1:0] w_cnt_val;

    function automatic logic [3:0] onehot_of(input logic [1:0] code);
        return 4'(4'b0001 << code);
    endfunction

    // Handshake flags depend on state flops only, never on out_ready.
    assign w_in_ready  = (r_state != FULL);
    assign w_out_valid = (r_state != EMPTY);
    assign w_push      = bus.in_valid && w_in_ready;
    assign w_pop       = w_out_valid && bus.out_ready;

    assign bus.in_ready   = w_in_ready;
    assign bus.out_valid  = w_out_valid;
    assign bus.out_onehot = r_onehot;
    assign bus.cnt_val    = w_cnt_val;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= EMPTY;
            r_head   <= 2'b00;
            r_tail   <= 2'b00;
            r_onehot <= 4'b0000;
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_push) begin
                        r_state  <= ONE;
                        r_head   <= bus.in_code;
                        r_onehot <= onehot_of(bus.in_code);
                    end
                end
                ONE: begin
                    if (w_push && w_pop) begin
                        r_head   <= bus.in_code;
                        r_onehot <= onehot_of(bus.in_code);
                    end else if (w_push) begin
                        r_state <= FULL;
                        r_tail  <= bus.in_code;
                    end else if (w_pop) begin
                        r_state  <= EMPTY;
                        r_onehot <= 4'b0000;
                    end
                end
                FULL: begin
                    if (w_pop) begin
                        r_state  <= ONE;
                        r_head   <= r_tail;
                        r_onehot <= onehot_of(r_tail);
                    end
                end
                default: begin
                    r_state  <= EMPTY;
                    r_onehot <= 4'b0000;
                end
            endcase
        end
    end

`ifdef DECODER_2X4_STREAM_CNT_EN
    logic [CNT_W-1:0] r_cnt [4];

    // Clear wins over a same-cycle increment; counts saturate at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (bus.clr_cnt) begin
            for (int i = 0; i < 4; i++) r_cnt[i] <= '0;
        end else if (w_pop && (r_cnt[r_head] != {CNT_W{1'b1}})) begin
            r_cnt[r_head] <= r_cnt[r_head] + CNT_W'(1);
        end
    end

    assign w_cnt_val = r_cnt[bus.cnt_sel];
`else
    logic w_unused_cnt_ctrl;

    assign w_unused_cnt_ctrl = ^{bus.clr_cnt, bus.cnt_sel};
    assign w_cnt_val         = '0;
`endif

endmodule

// File: tb/tb_decoder_2x4_stream.sv
// Scoreboard bench for decoder_2x4_stream: accepted codes queue their expected one-hot
// word, an independent monitor pops and compares on every output transfer.
module tb_decoder_2x4_stream;

    localparam int unsigned CNT_W = 2;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    logic [3:0] exp_q [$];

    decoder_2x4_stream_if #(.CNT_W(CNT_W)) bus ();

    decoder_2x4_stream #(.CNT_W(CNT_W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    // Drive one cycle of inputs; record the expected word if the push will be taken.
    task automatic drive(input logic v, input logic [1:0] c, input logic ordy, input logic clr);
        logic [3:0] w;
        bus.in_valid  = v;
        bus.in_code   = c;
        bus.out_ready = ordy;
        bus.clr_cnt   = clr;
        w = 4'b0001 << c;
        if (v && bus.in_ready) exp_q.push_back(w);
        cyc();
    endtask

    task automatic check_out(input string name, input logic vld, input logic rdy, input logic [3:0] oh);
        check({name, "_valid"}, 8'(bus.out_valid), 8'(vld));
        check({name, "_ready"}, 8'(bus.in_ready), 8'(rdy));
        check({name, "_onehot"}, 8'(bus.out_onehot), 8'(oh));
    endtask

    // Monitor: inputs settle 1ns after posedge, so the negedge sees the coming transfer.
    always @(negedge clk) begin
        if (rst_n && bus.out_valid && bus.out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL sb_unexpected: got %b want no word", bus.out_onehot);
            end else begin
                check("sb_word", 8'(bus.out_onehot), 8'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_code   = 2'd0;
        bus.out_ready = 1'b0;
        bus.clr_cnt   = 1'b0;
        bus.cnt_sel   = 2'd0;
        cyc();
        cyc();
        check_out("reset", 1'b0, 1'b1, 4'b0000);
        check("reset_cnt", 8'(bus.cnt_val), 8'd0);
        rst_n = 1'b1;

        // Single push under backpressure
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        check_out("single", 1'b1, 1'b1, 4'b0100);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check_out("single_drain", 1'b0, 1'b1, 4'b0000);

        // Fill, hold under backpressure, then drain
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        check_out("full", 1'b1, 1'b0, 4'b0010);
        drive(1'b1, 2'd0, 1'b0, 1'b0);
        check_out("full_hold", 1'b1, 1'b0, 4'b0010);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check_out("full_pop1", 1'b1, 1'b1, 4'b1000);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check_out("full_pop2", 1'b0, 1'b1, 4'b0000);

        // Streaming with no bubbles
        for (int c = 0; c < 4; c++) begin
            drive(1'b1, 2'(c), 1'b1, 1'b0);
            check_out($sformatf("stream%0d", c), 1'b1, 1'b1, 4'(4'b0001 << c));
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check_out("stream_end", 1'b0, 1'b1, 4'b0000);

        // Code ignored without in_valid
        drive(1'b0, 2'd3, 1'b0, 1'b0);
        drive(1'b0, 2'd1, 1'b1, 1'b0);
        check_out("no_push", 1'b0, 1'b1, 4'b0000);

        // Simultaneous push and pop in ONE
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        check_out("one_head3", 1'b1, 1'b1, 4'b1000);
        drive(1'b1, 2'd0, 1'b1, 1'b0);
        check_out("one_pushpop", 1'b1, 1'b1, 4'b0001);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check_out("one_drain", 1'b0, 1'b1, 4'b0000);

`ifdef DECODER_2X4_STREAM_CNT_EN
        // Counters: saturation and clear priority
        bus.cnt_sel = 2'd1;
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        check("cnt_cleared", 8'(bus.cnt_val), 8'd0);
        for (int i = 0; i < 5; i++) drive(1'b1, 2'd1, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check("cnt_sat", 8'(bus.cnt_val), 8'd3);
        bus.cnt_sel = 2'd2;
        #1;
        check("cnt_other", 8'(bus.cnt_val), 8'd0);
        bus.cnt_sel = 2'd1;
        drive(1'b0, 2'd0, 1'b0, 1'b1);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b1);
        check("cnt_clr_prio", 8'(bus.cnt_val), 8'd0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check("cnt_inc", 8'(bus.cnt_val), 8'd1);
`else
        // Counters absent: readback stays zero whatever the controls do
        for (int s = 0; s < 4; s++) begin
            bus.cnt_sel = 2'(s);
            drive(1'b1, 2'(s), 1'b1, 1'(s % 2));
            check($sformatf("cnt_off%0d", s), 8'(bus.cnt_val), 8'd0);
        end
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check_out("cnt_off_drain", 1'b0, 1'b1, 4'b0000);
`endif

        // Asynchronous reset in FULL discards both entries
        drive(1'b1, 2'd2, 1'b0, 1'b0);
        drive(1'b1, 2'd1, 1'b0, 1'b0);
        check_out("pre_rst", 1'b1, 1'b0, 4'b0100);
        bus.in_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_rst", 1'b0, 1'b1, 4'b0000);
        check("async_rst_cnt", 8'(bus.cnt_val), 8'd0);
        exp_q.delete();
        cyc();
        rst_n = 1'b1;
        drive(1'b1, 2'd3, 1'b0, 1'b0);
        check_out("post_rst_push", 1'b1, 1'b1, 4'b1000);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        drive(1'b0, 2'd0, 1'b1, 1'b0);
        check_out("post_rst_empty", 1'b0, 1'b1, 4'b0000);

        check("sb_leftover", 8'(exp_q.size()), 8'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/decoder_2x4_stream.md
DECODER_2X4_STREAM -- requirements
Module: decoder_2x4_stream

Interface
REQ-001 Parameter: CNT_W, default 8, width of each per-code transfer counter.
REQ-002 Port: clk  input  1  single clock; all flops sample on rising edge.
REQ-003 Port: rst_n  input  1  reset; asynchronous assert, active-low.
REQ-004 Port: in_valid  input  1  upstream code valid.
REQ-005 Port: in_ready  output  1  block can accept a code this cycle.
REQ-006 Port: in_code  input  2  binary code, values 0..3.
REQ-007 Port: out_valid  output  1  one-hot word valid.
REQ-008 Port: out_ready  input  1  downstream accepts the word.
REQ-009 Port: out_onehot  output  4  decoded one-hot word.
REQ-010 Port: clr_cnt  input  1  synchronous clear of all transfer counters.
REQ-011 Port: cnt_sel  input  2  selects the counter shown on cnt_val.
REQ-012 Port: cnt_val  output  CNT_W  value of the selected counter.

Function
REQ-013 The block SHALL be a 2-entry FIFO of 2-bit codes with FSM states EMPTY, ONE and FULL.
REQ-014 The block SHALL accept a code when in_valid && in_ready at a rising edge.
REQ-015 The block SHALL complete an output transfer when out_valid && out_ready at a rising edge.
REQ-016 in_ready SHALL be 1 in EMPTY and ONE, 0 in FULL, and SHALL be decoded from state flops only, with no combinational path from out_ready.
REQ-017 out_valid SHALL be 1 in ONE and FULL and 0 in EMPTY.
REQ-018 out_onehot SHALL be 4'b0001 << head_code while out_valid=1, and SHALL be 4'b0000 while out_valid=0.
REQ-019 Transitions SHALL be as follows:
- EMPTY: push -> ONE.
- ONE: push only -> FULL; pop only -> EMPTY; push and pop -> ONE, with the new code becoming head.
- FULL: pop -> ONE, with the second entry becoming head. Push cannot occur in FULL.
- No push and no pop: hold the current state.
REQ-020 Latency SHALL be 1 cycle: a code accepted at edge k SHALL appear on out_onehot with out_valid=1 immediately after edge k.
REQ-021 With in_valid=1 and out_ready=1 held, throughput SHALL be one word per cycle with no bubbles.
REQ-022 Order SHALL be strictly FIFO, and no code SHALL be dropped or duplicated.
REQ-023 Head data SHALL remain stable while out_valid=1 && out_ready=0.
REQ-024 in_code SHALL be ignored when no push occurs.

Reset
REQ-025 While rst_n=0, state SHALL be EMPTY, both entries SHALL be 2'b00 and all counters SHALL be 0. Consequently in_ready=1, out_valid=0, out_onehot=4'b0000 and cnt_val=0.
REQ-026 Reset asserted mid-stream SHALL discard buffered codes immediately, without waiting for a clock edge.
REQ-027 The first push SHALL be possible at the first rising edge after rst_n deasserts.

Configuration
REQ-028 Macro DECODER_2X4_STREAM_CNT_EN SHALL control the per-code counters.
REQ-029 With DECODER_2X4_STREAM_CNT_EN defined, the block SHALL behave as follows:
- It SHALL keep four CNT_W-bit counters, one per code.
- Counter[c] SHALL increment on each output transfer whose head code is c.
- Counters SHALL saturate at 2^CNT_W-1.
- clr_cnt=1 SHALL zero all counters at the next edge, with priority over a same-cycle increment.
- cnt_val SHALL equal counter[cnt_sel] combinationally.
REQ-030 With DECODER_2X4_STREAM_CNT_EN undefined, the block SHALL instantiate no counter flops, SHALL tie cnt_val to 0 and SHALL ignore clr_cnt and cnt_sel. FIFO behaviour SHALL be identical to the defined case.

Verification
REQ-031 Reset then single push: in_code=2 pushed with out_ready=0 -> next cycle out_valid=1, out_onehot=4'b0100, in_ready=1.
REQ-032 Fill and backpressure: push 1 then 3 with out_ready=0 -> state FULL, in_ready=0, out_onehot=4'b0010. Raise out_ready -> 4'b0010 then 4'b1000, then out_valid=0.
REQ-033 Streaming: codes 0,1,2,3 on consecutive cycles with out_ready=1 -> outputs 0001,0010,0100,1000 on 4 consecutive cycles, in_ready stays 1.
REQ-034 Simultaneous push/pop in ONE: head=3, push 0 while popping -> state ONE, out_onehot=4'b0001.
REQ-035 Reset mid-operation: assert rst_n=0 in FULL between edges -> out_valid=0 and in_ready=1 immediately, and no stale word appears after release.
REQ-036 Counters (macro defined, CNT_W=2): 5 transfers of code 1 -> cnt_sel=1 gives cnt_val=3 (saturated). Asserting clr_cnt in the same cycle as a transfer -> cnt_val=0. Macro undefined -> cnt_val=0 always.
